seg_display_driver: RTL
=======================

SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 Parameter BLINK_FRAMES, default 30, frames per blink half-period (1 frame = 8 clk_out cycles).
REQ-002 clk_out  input  1  display refresh clock (480 Hz); all state SHALL change on its rising edge only.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 S  input  3  digit select from the scan controller; digit index 0..7.
REQ-005 anode_in  input  8  active-low one-hot anode from the scan controller.
REQ-006 data_in  input  32  display word; nibble k (bits 4k+3:4k) is shown on digit k.
REQ-007 load_req  input  1  level request to adopt data_in at the next frame boundary.
REQ-008 dp_in  input  8  decimal-point enable per digit, active-high.
REQ-009 lz_blank_en  input  1  leading-zero blanking enable.
REQ-010 blink_mask  input  8  per-digit blink enable (present only with SEG_BLINK_EN).
REQ-011 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-012 dp  output  1  decimal-point cathode, active-low, registered.
REQ-013 anode_out  output  8  active-low anode, registered, aligned with seg/dp.
REQ-014 load_ack  output  1  one-cycle pulse when data_in is adopted.

Function
REQ-015 Each rising edge SHALL register seg, dp and anode_out for the digit given by the S sampled at that edge; latency exactly 1 clk_out cycle, outputs mutually aligned.
REQ-016 seg SHALL be the hex decode of nibble S of the active register: 0->1000000, 1->1111001, 8->0000000, A->0001000, F->0001110, full 0-F table per package constants.
REQ-017 dp SHALL equal ~dp_in[S]; anode_out SHALL equal anode_in, unmodified, when the digit is not blanked.
REQ-018 Frame boundary = an edge at which sampled S == 7.
REQ-019 At a frame boundary with load_req == 1, the active register SHALL load data_in and load_ack SHALL be 1 for the following cycle only; otherwise load_ack SHALL be 0.
REQ-020 load_req outside a frame boundary SHALL have no effect; the active register SHALL never change mid-frame (no tearing).
REQ-021 load_req held high across consecutive boundaries SHALL reload and pulse load_ack at every boundary.
REQ-022 A leading-zero mask SHALL be registered together with the active register: digit k (k = 7..1) is a leading zero if nibbles 7..k are all zero; digit 0 is never a leading zero.
REQ-023 A blanked digit SHALL drive seg = 1111111, dp = 1, anode_out = 11111111 for its cycle.
REQ-024 Digit blanked if (lz_blank_en && lz_mask[S]) or blink condition (REQ-027) holds.
REQ-025 Non-one-hot anode_in SHALL be passed through unchanged; no error handling.

Reset
REQ-026 While reset is high: seg = 1111111, dp = 1, anode_out = 11111111, load_ack = 0, active register = 0, lz_mask = 11111110, frame counter = 0, blink phase = 0; reset asserted mid-frame SHALL abort immediately and the first post-reset cycle SHALL follow REQ-015 with active = 0.

Configuration
REQ-027 Macro SEG_BLINK_EN defined: a frame counter counts boundaries 0..BLINK_FRAMES-1, wraps to 0 and toggles blink phase on wrap; digit S is blanked when blink phase == 1 and blink_mask[S] == 1.
REQ-028 SEG_BLINK_EN undefined: no blink_mask port, no frame counter or phase register; no digit is ever blink-blanked.

Structure
REQ-029 Package seg_display_pkg SHALL hold the 16-entry segment encoding constants, blank pattern 1111111, digit count 8 and select width 3.
REQ-030 Combinational sub-module hex_to_seg (4-bit nibble -> 7-bit active-low cathodes) SHALL be instantiated once.

Verification
REQ-031 Reset, then S cycling 0..7 with one-hot anode_in, lz_blank_en = 0 -> every digit seg = 1000000, anode_out = anode_in delayed 1 cycle.
REQ-032 data_in = 32'h89ABCDEF, load_req pulsed at S = 3 only -> no load, load_ack stays 0; held through S = 7 -> load_ack pulse next cycle, digit 0 shows 0001110 (F) from the following frame.
REQ-033 Active = 32'h00000050, lz_blank_en = 1 -> digits 7..2 anode_out = FF, seg = 1111111; digit 1 shows 0010010 (5); digit 0 shows 1000000.
REQ-034 Active = 0, lz_blank_en = 1 -> only digit 0 lit with 1000000; dp_in = 8'h01 -> dp = 0 on digit 0 only.
REQ-035 SEG_BLINK_EN, BLINK_FRAMES = 2, blink_mask = 8'h80 -> digit 7 blanked in frames 2-3, 6-7, ...; other digits never blanked.
REQ-036 reset asserted at S = 4 after a load of 32'h12345678 -> outputs immediately at reset values; after release digit 0 shows 1000000.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment display driver: segment encodings,
// blank pattern, digit count and digit-select width, plus the leading-zero
// mask helper used when a new display word is adopted.
package seg_display_pkg;

   localparam int DIGITS = 8;
   localparam int SEL_W  = 3;
   localparam int WORD_W = 4 * DIGITS;

   // Cathodes {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000,   // 0
      7'b1111001,   // 1
      7'b0100100,   // 2
      7'b0110000,   // 3
      7'b0011001,   // 4
      7'b0010010,   // 5
      7'b0000010,   // 6
      7'b1111000,   // 7
      7'b0000000,   // 8
      7'b0010000,   // 9
      7'b0001000,   // A
      7'b0000011,   // b
      7'b1000110,   // C
      7'b0100001,   // d
      7'b0000110,   // E
      7'b0001110    // F
   };

   // Digit k (k >= 1) is a leading zero when nibbles DIGITS-1 down to k are
   // all zero. Digit 0 always stays lit so a zero word still shows "0".
   function automatic logic [DIGITS-1:0] lz_mask_of(input logic [WORD_W-1:0] word);
      logic [DIGITS-1:0] mask;
      logic              zero_run;
      mask     = '0;
      zero_run = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_run = zero_run && (word[4*k +: 4] == 4'h0);
         mask[k]  = zero_run;
      end
      return mask;
   endfunction

endpackage

// File: rtl/seg_display_driver_if.sv
// Bundle between the scan controller and the display driver.
// The scan controller side is the master (drives select, anode, data, requests);
// the driver is the slave (returns cathodes, anode and load acknowledge).
// blink_mask exists only when SEG_BLINK_EN is defined.
interface seg_display_driver_if;
   import seg_display_pkg::*;

   logic [SEL_W-1:0]  S;
   logic [DIGITS-1:0] anode_in;
   logic [WORD_W-1:0] data_in;
   logic              load_req;
   logic [DIGITS-1:0] dp_in;
   logic              lz_blank_en;
`ifdef SEG_BLINK_EN
   logic [DIGITS-1:0] blink_mask;
`endif
   logic [6:0]        seg;
   logic              dp;
   logic [DIGITS-1:0] anode_out;
   logic              load_ack;

   modport master (
      output S, anode_in, data_in, load_req, dp_in, lz_blank_en,
`ifdef SEG_BLINK_EN
      output blink_mask,
`endif
      input  seg, dp, anode_out, load_ack
   );

   modport slave (
      input  S, anode_in, data_in, load_req, dp_in, lz_blank_en,
`ifdef SEG_BLINK_EN
      input  blink_mask,
`endif
      output seg, dp, anode_out, load_ack
   );

endinterface

// File: rtl/seg_display_driver_hex_to_seg.sv
// Purpose: 4-bit nibble to active-low {g,f,e,d,c,b,a} cathode pattern.
// Latency: combinational.
// Backpressure: none.
module hex_to_seg
   import seg_display_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_display_driver.sv
// Purpose: registers cathodes/anode for the digit being scanned, with frame-synchronous
//          word adoption, leading-zero blanking and optional blink (macro SEG_BLINK_EN).
// Latency: 1 clk_out cycle from S/anode_in/dp_in to seg/dp/anode_out; load_ack 1 cycle after boundary.
// Backpressure: none; load_req is only honoured at a frame boundary (S == 7), otherwise ignored.
module seg_display_driver
   import seg_display_pkg::*;
#(
   parameter int BLINK_FRAMES = 30
)(
   input  logic                clk_out,
   input  logic                reset,
   seg_display_driver_if.slave bus
);

   logic [WORD_W-1:0] active_q;
   logic [DIGITS-1:0] lz_mask_q;
   logic              boundary;
   logic              load_now;
   logic [3:0]        nibble;
   logic [6:0]        hex_seg;
   logic              lz_blank;
   logic              blink_blank;
   logic              blank;

   assign boundary = (bus.S == SEL_W'(DIGITS - 1));
   assign load_now = boundary && bus.load_req;

   // Pick the nibble of the active word for the digit currently being scanned.
   always_comb begin
      nibble = active_q[{bus.S, 2'b00} +: 4];
   end

   hex_to_seg u_hex_to_seg (
      .nibble (nibble),
      .seg    (hex_seg)
   );

`ifdef SEG_BLINK_EN
   localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [FC_W-1:0] frame_cnt_q;
   logic            blink_phase_q;

   // Count frame boundaries; each wrap flips the blink phase.
   always_ff @(posedge clk_out or posedge reset) begin
      if (reset) begin
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else if (boundary) begin
         if (frame_cnt_q == FC_W'(BLINK_FRAMES - 1)) begin
            frame_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
         end else begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
         end
      end
   end

   assign blink_blank = blink_phase_q && bus.blink_mask[bus.S];
`else
   assign blink_blank = 1'b0;
`endif

   assign lz_blank = bus.lz_blank_en && lz_mask_q[bus.S];
   assign blank    = lz_blank || blink_blank;

   // Adopt the new word only at a frame boundary so a frame never tears;
   // the leading-zero mask is captured from the same word.
   always_ff @(posedge clk_out or posedge reset) begin
      if (reset) begin
         active_q     <= '0;
         lz_mask_q    <= lz_mask_of('0);
         bus.load_ack <= 1'b0;
      end else begin
         bus.load_ack <= load_now;
         if (load_now) begin
            active_q  <= bus.data_in;
            lz_mask_q <= lz_mask_of(bus.data_in);
         end
      end
   end

   // Register the displayed digit; blanked digits drive everything inactive.
   always_ff @(posedge clk_out or posedge reset) begin
      if (reset) begin
         bus.seg       <= SEG_BLANK;
         bus.dp        <= 1'b1;
         bus.anode_out <= '1;
      end else if (blank) begin
         bus.seg       <= SEG_BLANK;
         bus.dp        <= 1'b1;
         bus.anode_out <= '1;
      end else begin
         bus.seg       <= hex_seg;
         bus.dp        <= ~bus.dp_in[bus.S];
         bus.anode_out <= bus.anode_in;
      end
   end

endmodule
